mult_div_sequencer: RTL

Multi-cycle unsigned multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It executes MULTU and DIVU iteratively, one bit per clock, writes the HI/LO register pair, and raises a stall to the hazard logic while an operation is in flight. The ALU keeps single-cycle ops; the main decoder routes only MULTU/DIVU here via `start`/`op`.

---
 rtl/mult_div_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative unsigned MULTU/DIVU unit for the EX stage.
// One bit per clock: shift-add multiply, restoring divide. Writes the HI/LO
// pair only on the completion edge and stalls IF/ID/EX while in flight.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, op            request (op 0 = MULTU, 1 = DIVU), sampled when accepting
//   operand_a/operand_b  rs / rt values
//   flush                synchronous abort, wins over start and completion
//   busy                 registered, high while iterating
//   stall                combinational, busy | (start & accept)
//   done                 registered one-cycle pulse when HI/LO update
//   div_by_zero          registered, sticky until the next accepted start
//   hi, lo               HI/LO registers
module mult_div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    // MUL: {running upper half, remaining multiplier bits}.
    // DIV: low half holds dividend bits shifting out / quotient bits shifting in.
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH:0]         rem_q, rem_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;

    logic                   accept;
    logic                   last;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH+1:0]       rem_sh;
    logic [WIDTH+1:0]       div_diff;
    logic                   div_ge;
    logic [WIDTH:0]         rem_next;
    logic [WIDTH-1:0]       quo_next;

    assign accept = (state_q == StIdle) || (state_q == StDone);
    assign last   = (cnt_q == CntW'(WIDTH - 1));

    // Shift-add step; the carry out of the add becomes the new MSB after the shift.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Restoring step; the extra top bit of the difference is the sign.
    always_comb begin
        rem_sh   = {rem_q, acc_q[WIDTH-1]};
        div_diff = rem_sh - {2'b00, opb_q};
        div_ge   = ~div_diff[WIDTH+1];
        rem_next = div_ge ? div_diff[WIDTH:0] : rem_sh[WIDTH:0];
        quo_next = {acc_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    opb_d   = op ? operand_b : operand_a;
                    acc_d   = {{WIDTH{1'b0}}, (op ? operand_a : operand_b)};
                    state_d = op ? StDiv : StMul;
                end else begin
                    state_d = StIdle;
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CntW'(1);
                if (last) begin
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_next[WIDTH-1:0];
                    state_d = StDone;
                end
            end
            StDiv: begin
                if (opb_q == '0) begin
                    // Divide by zero completes after a single edge.
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    rem_d             = rem_next;
                    acc_d[WIDTH-1:0]  = quo_next;
                    cnt_d             = cnt_q + CntW'(1);
                    if (last) begin
                        hi_d    = rem_next[WIDTH-1:0];
                        lo_d    = quo_next;
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort keeps the architectural HI/LO and the sticky flag untouched.
        if (flush) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end

        busy_d = (state_d == StMul) || (state_d == StDiv);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign stall       = busy_q | (start & accept);

endmodule
